// File: rtl/rr_grant_sched8.sv
// rr_grant_sched8: eight-way round-robin grant scheduler with a hold limit.
// A grant is held while its owner keeps requesting. It is ended early when the
// owner has used MAX_HOLD consecutive cycles and another requester is waiting.
// All outputs are registered, and a release is always followed by one idle cycle.
//
// state | meaning
// IDLE  | no owner; arbitrate from ptr when enabled
// GRANT | one owner holds the resource; hold_cnt counts its cycles
module rr_grant_sched8 #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            preempt_q, preempt_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;

  logic [2:0]      win_idx;
  logic [2:0]      scan_idx;
  logic [7:0]      others;

  // Pick the first set request at or after ptr, wrapping modulo 8.
  // The scan runs from the farthest offset down, so the nearest one is assigned last and wins.
  always_comb begin
    win_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      scan_idx = ptr_q + 3'(i);
      if (req[scan_idx]) win_idx = scan_idx;
    end
  end

  // Requests from everyone except the current owner; used to detect contention.
  always_comb begin
    others = req & ~(8'h01 << gnt_idx_q);
  end

  // Next-state and next-output decisions for the grant FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        if (en && (req != 8'h00)) begin
          gnt_d       = 8'h01 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!en || !req[gnt_idx_q] ||
            ((hold_cnt_q == HOLD_LIM) && (others != 8'h00))) begin
          // gnt_idx keeps the released owner; the next search starts just past it.
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
          ptr_d       = gnt_idx_q + 3'd1;
          preempt_d   = en && req[gnt_idx_q];
        end else if (hold_cnt_q != HOLD_LIM) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // Register every state and output bit; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_sched8.sv
// Bench for rr_grant_sched8: two instances (hold limits 4 and 16) share one
// stimulus. A cycle-level ownership model is compared against both instances
// on every falling edge. Directed literal expectations pin the model.
module tb_rr_grant_sched8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       valid_a, valid_b, pre_a, pre_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model state per instance: owner (-1 = none), last owner, search start,
  // cycles held so far, and the preempt pulse.
  int own[2];
  int last[2];
  int ptr[2];
  int held[2];
  bit pre[2];
  int mh[2];

  rr_grant_sched8 #(.MAX_HOLD(4), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a), .preempt(pre_a)
  );

  rr_grant_sched8 #(.MAX_HOLD(16), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b), .preempt(pre_b)
  );

  always #5 clk = ~clk;

  initial begin
    mh[0] = 4;
    mh[1] = 16;
    for (int m = 0; m < 2; m++) begin
      own[m] = -1; last[m] = 0; ptr[m] = 0; held[m] = 0; pre[m] = 1'b0;
    end
  end

  // Model: an owner keeps the resource while it requests and is enabled. It gives
  // it up after mh cycles if anyone else asks. A new owner is chosen only from an
  // empty cycle, so one free cycle always separates two owners.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        own[m] = -1; last[m] = 0; ptr[m] = 0; held[m] = 0; pre[m] = 1'b0;
      end else begin
        pre[m] = 1'b0;
        if (own[m] < 0) begin
          if (en && req != 8'h00) begin
            for (int k = 7; k >= 0; k--)
              if (req[(ptr[m] + k) % 8]) own[m] = (ptr[m] + k) % 8;
            last[m] = own[m];
            held[m] = 1;
          end
        end else if (!en || !req[own[m]]) begin
          ptr[m] = (own[m] + 1) % 8;
          own[m] = -1;
        end else if (held[m] >= mh[m] && (req & ~(8'h01 << own[m])) != 8'h00) begin
          ptr[m] = (own[m] + 1) % 8;
          own[m] = -1;
          pre[m] = 1'b1;
        end else if (held[m] < 100000) begin
          held[m] = held[m] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int m, input logic [7:0] g, input logic [2:0] ix,
                            input logic v, input logic p);
    logic [7:0] eg;
    eg = (own[m] < 0) ? 8'h00 : (8'h01 << own[m]);
    check($sformatf("model_gnt[%0d]", m), int'(g), int'(eg));
    check($sformatf("model_idx[%0d]", m), int'(ix), last[m]);
    check($sformatf("model_valid[%0d]", m), int'(v), (own[m] >= 0) ? 1 : 0);
    check($sformatf("model_preempt[%0d]", m), int'(p), int'(pre[m]));
  endtask

  // Every cycle after reset, both instances must agree with the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check_inst(0, gnt_a, idx_a, valid_a, pre_a);
      check_inst(1, gnt_b, idx_b, valid_b, pre_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] alt_g [11];
  logic       alt_p [11];

  initial begin
    alt_g = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02};
    alt_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk_on = 1'b1;

    // Idle with no requests.
    en = 1'b1;
    req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_gnt", gnt_a, 8'h00);
      check("idle_valid", valid_a, 0);
      check("idle_idx", idx_a, 0);
      check("idle_preempt", pre_a, 0);
    end

    // Rotation: 2 then 7, then wrap to 0.
    req = 8'h84;
    tick(); check("rot_gnt2", gnt_a, 8'h04); check("rot_idx2", idx_a, 2);
    req = 8'h80;
    tick(); check("rot_gap1", gnt_a, 8'h00); check("rot_gap1_idx", idx_a, 2);
    tick(); check("rot_gnt7", gnt_a, 8'h80); check("rot_idx7", idx_a, 7);
    req = 8'h01;
    tick(); check("rot_gap2", gnt_a, 8'h00);
    tick(); check("rot_gnt0", gnt_a, 8'h01); check("rot_idx0", idx_a, 0);
    req = 8'h00;
    tick(); check("rot_release", gnt_a, 8'h00);

    // Hold limit of 4 with two contenders (search starts at 1).
    req = 8'h03;
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("alt_gnt_%0d", i), gnt_a, alt_g[i]);
      check($sformatf("alt_pre_%0d", i), pre_a, alt_p[i]);
    end
    check("alt_b_hold", gnt_b, 8'h02);
    req = 8'h00;
    tick();
    tick();

    // Sole requester keeps the grant with no preempt.
    req = 8'h10;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      check("sole_gnt", gnt_b, 8'h10);
      check("sole_pre", pre_b, 0);
      check("sole_gnt_a", gnt_a, 8'h10);
    end

    // Disable mid-grant, then search from 4 reaches 0 before 3.
    req = 8'h08;
    tick(); check("en_gap", gnt_a, 8'h00);
    tick(); check("en_gnt3", gnt_a, 8'h08);
    en = 1'b0;
    tick(); check("en_drop", gnt_a, 8'h00); check("en_drop_idx", idx_a, 3);
    check("en_drop_pre", pre_a, 0);
    en = 1'b1;
    req = 8'h09;
    tick(); check("en_regrant", gnt_a, 8'h01); check("en_regrant_idx", idx_a, 0);

    // Reset mid-grant.
    req = 8'h20;
    tick(); check("rst_gap", gnt_a, 8'h00);
    tick(); check("rst_gnt5", gnt_a, 8'h20);
    rst = 1'b1;
    tick(); check("rst_gnt", gnt_a, 8'h00); check("rst_idx", idx_a, 0);
    check("rst_valid", valid_a, 0);
    rst = 1'b0;
    req = 8'h21;
    tick(); check("rst_ptr0", gnt_a, 8'h01); check("rst_ptr0_b", gnt_b, 8'h01);
    req = 8'h00;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
